// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the 16-line interrupt priority controller.
package irq_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned ID_W  = 4;

  localparam logic [N_REQ-1:0] MASK_RST = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE
  } irq_state_t;

endpackage

// File: rtl/prio_enc16.sv
// 16-input combinational priority encoder; the highest set bit wins.
module prio_enc16
  import irq_pkg::*;
(
  input  logic [N_REQ-1:0] i_vec,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    // Ascending scan so later (higher) indices overwrite lower ones.
    for (int i = 0; i < N_REQ; i++) begin
      if (i_vec[i]) begin
        o_idx   = i[ID_W-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_priority_ctrl.sv
// Edge-detecting, maskable 16-line interrupt controller with an irq/ack/eoi handshake.
// Define IRQ_ROUND_ROBIN_EN to rotate priority so the last acked line becomes lowest.
module irq_priority_ctrl
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             mask_we,
  input  logic [N_REQ-1:0] mask_wdata,
  input  logic             ack,
  input  logic             eoi,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] mask
);

  irq_state_t       r_state;
  logic [N_REQ-1:0] r_req_d;
  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] r_mask;
  logic             r_irq;
  logic [ID_W-1:0]  r_irq_id;
  logic             r_in_service;

  logic [N_REQ-1:0] w_set_vec;
  logic [N_REQ-1:0] w_clr_vec;
  logic [N_REQ-1:0] w_cand;
  logic [N_REQ-1:0] w_enc_in;
  logic [ID_W-1:0]  w_enc_idx;
  logic             w_enc_valid;
  logic [ID_W-1:0]  w_winner;
  logic             w_ack_take;

  assign w_set_vec  = req & ~r_req_d;
  assign w_ack_take = (r_state == ASSERT) && ack;
  assign w_clr_vec  = w_ack_take ? (N_REQ'(1) << r_irq_id) : '0;
  assign w_cand     = r_pending & ~r_mask;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0]    r_last;
  logic [2*N_REQ-1:0] w_dbl;

  // Bit j of the rotated vector is line (j + last) mod 16, so line last-1 lands on bit 15.
  assign w_dbl    = {w_cand, w_cand} >> r_last;
  assign w_enc_in = w_dbl[N_REQ-1:0];
  assign w_winner = w_enc_idx + r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
    end else if (w_ack_take) begin
      r_last <= r_irq_id;
    end
  end
`else
  assign w_enc_in = w_cand;
  assign w_winner = w_enc_idx;
`endif

  prio_enc16 u_prio_enc16 (
    .i_vec   (w_enc_in),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_req_d      <= '0;
      r_pending    <= '0;
      r_mask       <= MASK_RST;
      r_irq        <= 1'b0;
      r_irq_id     <= '0;
      r_in_service <= 1'b0;
    end else begin
      r_req_d <= req;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
      // A new edge on the line being acked wins over the clear.
      r_pending <= (r_pending & ~w_clr_vec) | w_set_vec;
      unique case (r_state)
        IDLE: begin
          if (w_enc_valid) begin
            r_irq_id <= w_winner;
            r_irq    <= 1'b1;
            r_state  <= ASSERT;
          end
        end
        ASSERT: begin
          if (ack) begin
            r_irq        <= 1'b0;
            r_in_service <= 1'b1;
            r_state      <= SERVICE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            r_in_service <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign irq        = r_irq;
  assign irq_id     = r_irq_id;
  assign in_service = r_in_service;
  assign pending    = r_pending;
  assign mask       = r_mask;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed self-checking bench for irq_priority_ctrl; expectations follow IRQ_ROUND_ROBIN_EN.
module tb_irq_priority_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        mask_we;
  logic [15:0] mask_wdata;
  logic        ack;
  logic        eoi;
  logic        irq;
  logic [3:0]  irq_id;
  logic        in_service;
  logic [15:0] pending;
  logic [15:0] mask;

  int total = 0;
  int bad   = 0;

  irq_priority_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .eoi        (eoi),
    .irq        (irq),
    .irq_id     (irq_id),
    .in_service (in_service),
    .pending    (pending),
    .mask       (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_mask(input logic [15:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic ack_eoi();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  int exp_rr [4];

  initial begin
    rst_n = 1'b0; req = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; eoi = 1'b0;
    #12;
    check("rst_irq", 16'(irq), 16'h0);
    check("rst_id", 16'(irq_id), 16'h0);
    check("rst_insvc", 16'(in_service), 16'h0);
    check("rst_pending", pending, 16'h0000);
    check("rst_mask", mask, 16'hFFFF);
    rst_n = 1'b1;
    tick();

    // Basic latency on line 5
    write_mask(16'h0000);
    check("mask_clear", mask, 16'h0000);
    check("idle_irq", 16'(irq), 16'h0);
    req = 16'h0020;
    tick();
    req = '0;
    check("l5_pending", pending, 16'h0020);
    check("l5_irq_early", 16'(irq), 16'h0);
    tick();
    check("l5_irq", 16'(irq), 16'h1);
    check("l5_id", 16'(irq_id), 16'd5);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("l5_ack_irq", 16'(irq), 16'h0);
    check("l5_insvc", 16'(in_service), 16'h1);
    check("l5_ack_pending", pending, 16'h0000);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("l5_eoi_insvc", 16'(in_service), 16'h0);
    check("l5_id_hold", 16'(irq_id), 16'd5);

    // Two simultaneous lines, highest first, then back-to-back
    req = 16'h1008;
    tick();
    req = '0;
    check("p2_pending", pending, 16'h1008);
    tick();
    check("p2_id12", 16'(irq_id), 16'd12);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("p2_ack_pending", pending, 16'h0008);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("p2_eoi_irq", 16'(irq), 16'h0);
    tick();
    check("p2_b2b_irq", 16'(irq), 16'h1);
    check("p2_b2b_id3", 16'(irq_id), 16'd3);
    ack_eoi();

    // Masked line sets pending but is not selected
    write_mask(16'h0100);
    req = 16'h0100;
    tick();
    req = '0;
    check("m_pending", pending, 16'h0100);
    tick();
    tick();
    check("m_irq_blocked", 16'(irq), 16'h0);
    ack = 1'b1;  // ack outside ASSERT is ignored
    tick();
    ack = 1'b0;
    check("m_ack_ignored", pending, 16'h0100);
    write_mask(16'h0000);
    check("m_old_mask_sel", 16'(irq), 16'h0);
    tick();
    check("m_irq", 16'(irq), 16'h1);
    check("m_id8", 16'(irq_id), 16'd8);
    ack_eoi();

    // No preemption while in ASSERT; ack+eoi together only acks
    req = 16'h0080;
    tick();
    req = '0;
    tick();
    check("np_id7", 16'(irq_id), 16'd7);
    req = 16'h8000;
    tick();
    req = '0;
    check("np_pending", pending, 16'h8080);
    tick();
    check("np_id_frozen", 16'(irq_id), 16'd7);
    check("np_irq_held", 16'(irq), 16'h1);
    ack = 1'b1;
    eoi = 1'b1;
    tick();
    ack = 1'b0;
    eoi = 1'b0;
    check("np_ack_eoi_insvc", 16'(in_service), 16'h1);
    check("np_ack_pending", pending, 16'h8000);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    check("np_id15", 16'(irq_id), 16'd15);
    ack_eoi();

    // Set wins over ack-clear on the same line, then async reset in SERVICE
    req = 16'h0010;
    tick();
    req = '0;
    tick();
    check("sw_id4", 16'(irq_id), 16'd4);
    ack = 1'b1;
    req = 16'h0010;
    tick();
    ack = 1'b0;
    req = '0;
    check("sw_pending", pending, 16'h0010);
    check("sw_insvc", 16'(in_service), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_irq", 16'(irq), 16'h0);
    check("ar_insvc", 16'(in_service), 16'h0);
    check("ar_pending", pending, 16'h0000);
    check("ar_mask", mask, 16'hFFFF);
    tick();
    rst_n = 1'b1;
    tick();

    // Lines 2 and 9 kept pending; rotation depends on the build option
`ifdef IRQ_ROUND_ROBIN_EN
    exp_rr = '{9, 2, 9, 2};
`else
    exp_rr = '{9, 9, 9, 9};
`endif
    write_mask(16'h0000);
    req = 16'h0204;
    tick();
    req = '0;
    tick();
    for (int g = 0; g < 4; g++) begin
      check($sformatf("rr_grant%0d", g), 16'(irq_id), 16'(exp_rr[g]));
      ack = 1'b1;
      tick();
      ack = 1'b0;
      eoi = 1'b1;
      req = 16'h0001 << exp_rr[g];
      tick();
      eoi = 1'b0;
      req = '0;
      tick();
    end
    check("rr_pending", pending, 16'h0204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
